// File: rtl/shared_inv_sched_pkg.sv
// Shared types and constants for the shared-inverter scheduler.
package shared_inv_sched_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam int unsigned CntW = 16;

endpackage

// File: rtl/inverter.sv
// W-bit bitwise inverter datapath.
module inverter #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] i_a,
  output logic [W-1:0] o_y
);

  assign o_y = ~i_a;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin selector: the search starts at i_ptr and wraps, and the first valid index wins.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = 2
) (
  input  logic [N-1:0]    i_req,
  input  logic [IdxW-1:0] i_ptr,
  input  logic            i_en,
  output logic [N-1:0]    o_gnt,
  output logic [IdxW-1:0] o_idx,
  output logic            o_found
);

  int unsigned c;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_found = 1'b0;
    c       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      c = int'(i_ptr) + k;
      if (c >= N) c = c - N;
      if (!o_found && i_req[c]) begin
        o_found = 1'b1;
        o_idx   = IdxW'(c);
      end
    end
    // Without enable the index is still computed, but nothing is granted.
    if (i_en && o_found) o_gnt[o_idx] = 1'b1;
  end

endmodule

// File: rtl/shared_inv_sched.sv
// Round-robin scheduler sharing one inverter among NUM_REQ requesters with a registered result.
// Optional per-requester grant counters are enabled by defining SHARED_INV_SCHED_STATS_EN.
module shared_inv_sched
  import shared_inv_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned W       = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*W-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rsp_valid,
  output logic [W-1:0]               rsp_data,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
`ifdef SHARED_INV_SCHED_STATS_EN
  output logic [NUM_REQ*CntW-1:0]    grant_cnt,
`endif
  input  logic                       rsp_ready
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  state_e            r_state, w_state_d;
  logic [W-1:0]      r_data;
  logic [IdxW-1:0]   r_id;
  logic [IdxW-1:0]   r_ptr;

  logic [NUM_REQ-1:0] w_gnt;
  logic [IdxW-1:0]    w_idx;
  logic               w_found;
  logic               w_slot_free;
  logic               w_xfer;
  logic [W-1:0]       w_operand;
  logic [W-1:0]       w_inv;

  // Reset gates the arbiter so a same-cycle transfer can never slip through.
  assign w_slot_free = (r_state == EMPTY) || rsp_ready;
  assign w_xfer      = |w_gnt;

  rr_arbiter #(
    .N    (NUM_REQ),
    .IdxW (IdxW)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .i_en    (w_slot_free && !rst),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx),
    .o_found (w_found)
  );

  always_comb begin
    w_operand = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_idx == IdxW'(i)) w_operand = req_data[i*W +: W];
    end
  end

  inverter #(
    .W (W)
  ) u_inv (
    .i_a (w_operand),
    .o_y (w_inv)
  );

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      EMPTY:   if (w_xfer) w_state_d = FULL;
      FULL:    if (!w_xfer && rsp_ready) w_state_d = EMPTY;
      default: w_state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_data  <= '0;
      r_id    <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_xfer) begin
        r_data <= w_inv;
        r_id   <= w_idx;
        r_ptr  <= (w_idx == IdxW'(NUM_REQ - 1)) ? '0 : w_idx + IdxW'(1);
      end
    end
  end

  assign req_ready = w_gnt;
  assign rsp_valid = (r_state == FULL);
  assign rsp_data  = r_data;
  assign rsp_id    = r_id;

`ifdef SHARED_INV_SCHED_STATS_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    logic [CntW-1:0] r_cnt;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt <= '0;
      end else if (w_gnt[g] && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CntW'(1);
      end
    end
    assign grant_cnt[g*CntW +: CntW] = r_cnt;
  end
`endif

  logic w_unused;
  assign w_unused = w_found;

endmodule

// File: doc/shared_inv_sched.md
SHARED_INV_SCHED -- requirements
Module: shared_inv_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..16).
REQ-002 SHALL have parameter W, default 8, data width in bits (>=1).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester request valid.
REQ-006 SHALL have port req_data  input  NUM_REQ*W  per-requester operand; requester i occupies bits [i*W +: W].
REQ-007 SHALL have port req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
REQ-008 SHALL have port rsp_valid  output  1  result valid.
REQ-009 SHALL have port rsp_data  output  W  result = bitwise inverse of the accepted operand.
REQ-010 SHALL have port rsp_id  output  $clog2(NUM_REQ)  index of the requester that owns rsp_data.
REQ-011 SHALL have port rsp_ready  input  1  downstream accept.

Function
REQ-012 SHALL share one W-bit inverter datapath among all requesters; requester i transfers when req_valid[i] && req_ready[i].
REQ-013 SHALL arbitrate round-robin: the search starts at rr_ptr and wraps NUM_REQ-1 -> 0; the first valid index wins.
REQ-014 SHALL update rr_ptr to (winner+1) mod NUM_REQ only on a transfer; with no transfer, rr_ptr holds.
REQ-015 SHALL drive req_ready high only for the winner, and only when the output slot is free or draining (!rsp_valid || rsp_ready).
REQ-016 SHALL register the result: a transfer at cycle N gives rsp_valid=1 at cycle N+1 with rsp_data=~operand and rsp_id=winner.
REQ-017 SHALL use FSM states EMPTY and FULL. EMPTY->FULL on transfer. FULL->EMPTY on rsp_ready without a new transfer. FULL stays FULL on stall, or on rsp_ready with a new transfer.
REQ-018 SHALL hold rsp_data and rsp_id stable while rsp_valid && !rsp_ready.
REQ-019 SHALL sustain one transfer per cycle when rsp_ready is held high (full throughput, no bubble).
REQ-020 SHALL let a requester withdraw req_valid before a transfer without side effects; rr_ptr is unaffected.
REQ-021 SHALL guarantee that each continuously-valid requester is granted within NUM_REQ transfers.

Reset
REQ-022 SHALL on rst force: state=EMPTY, rsp_valid=0, rsp_data=0, rsp_id=0, rr_ptr=0, req_ready=0.
REQ-023 SHALL, when rst is asserted while FULL, discard the pending result with no response emitted; rst has priority over any same-cycle transfer.

Configuration
REQ-024 SHALL, when SHARED_INV_SCHED_STATS_EN is defined, add output grant_cnt (NUM_REQ*16): one 16-bit saturating counter per requester, incremented on each transfer, cleared by rst.
REQ-025 SHALL, when SHARED_INV_SCHED_STATS_EN is undefined, omit the grant_cnt port and its counters entirely; all other behaviour is identical.

Structure
REQ-026 SHALL take the state enum (EMPTY, FULL) and the counter width constant (16) from package shared_inv_sched_pkg.
REQ-027 SHALL place round-robin selection in sub-module rr_arbiter (inputs: req vector, rr_ptr, enable; outputs: one-hot grant, grant index).
REQ-028 SHALL implement the inverter datapath as the existing W-parameterised inverter module, instantiated once.

Verification
REQ-029 SHALL cover: NUM_REQ=4, W=8, only req 2 valid with 0x5A and rsp_ready=1 -> cycle+1: rsp_valid=1, rsp_data=0xA5, rsp_id=2.
REQ-030 SHALL cover: all four requesters valid continuously, rsp_ready=1 -> grants in order 0,1,2,3,0, one per cycle.
REQ-031 SHALL cover: rsp_ready=0 for 3 cycles after one transfer -> rsp_data/rsp_id stable, all req_ready=0, rr_ptr unchanged.
REQ-032 SHALL cover: rr_ptr=3 with req 1 and req 3 valid -> grant 3, then grant 1 (wrap-around).
REQ-033 SHALL cover: rst asserted while FULL and req 0 valid -> next cycle rsp_valid=0, rr_ptr=0, no transfer recorded.
REQ-034 SHALL cover: with SHARED_INV_SCHED_STATS_EN defined, 70000 grants to req 0 -> grant_cnt[0] saturates at 0xFFFF.
